j_ofm_deshifter_mx_cell: RTL
============================

# j_ofm_deshifter_MX_cell

Eight-lane output-feature-map deshifter. It is the receive end of the weight/activation shifter stream. Each lane accepts SHIFT_WIDTH-bit beats qualified by `serial_en`, packs consecutive beats into SRAM words, and writes them to a per-lane SRAM bank starting at a per-lane base address. It sits between the systolic array's output lanes and the OFM SRAM banks. It is controlled by a start/idle handshake from the layer controller.

## Interface
- SRAM_DEPTH, 256*256*4, words per lane bank
- SHIFT_WIDTH, 8, bits per beat (one element)
- ELEMS_PER_WORD, 4, beats packed per SRAM word
- SRAM_ADDR_W, clog2(SRAM_DEPTH), address width
- SRAM_DATA_W, SHIFT_WIDTH*ELEMS_PER_WORD, derived; not overridable

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- write_start  in  1  one-cycle pulse; starts all lanes
- write_idle  out  1  AND of all lane idle flags
- base_addr  in  SRAM_ADDR_W*8  per-lane first write address; sampled at start
- img_size  in  SRAM_ADDR_W  elements per lane; sampled at start
- serial_input  in  SHIFT_WIDTH*8  lane i at [i*SHIFT_WIDTH +: SHIFT_WIDTH]
- serial_en  in  8  per-lane beat valid
- sram_we  out  8  per-lane write strobe
- sram_addr  out  SRAM_ADDR_W*8  per-lane write address
- sram_wdata  out  SRAM_DATA_W*8  per-lane packed word
- ovf_err  out  8  per-lane sticky protocol error; see Configuration

## Operation
- The top registers `write_start` once and fans it out to all 8 lanes. Lane start is therefore 1 cycle after `write_start`.
- Lane FSM states:
  - IDLE: lane_idle=1. On lane start, latch base_addr and img_size and clear counters. Go to RUN. If img_size==0, stay in IDLE with no writes.
  - RUN: on each cycle with serial_en=1, place the beat in slot `elem_cnt % ELEMS_PER_WORD`. The first beat goes to the LSBs.
    - When a slot fills the last position, or the accepted beat is element img_size-1, go to WRITE.
  - WRITE: on a single cycle, drive sram_we=1, the word at sram_addr = base + word_cnt, and the packed word. Then increment word_cnt.
    - Go back to RUN if elements remain; otherwise go to IDLE.
    - Unfilled slots of a final partial word are zero.
    - A beat that arrives during WRITE is accepted into the next word. The pack register is double-buffered, so no beat is lost.
- Address arithmetic is modulo 2^SRAM_ADDR_W, so base + word_cnt wraps silently.
- Total words per lane = ceil(img_size / ELEMS_PER_WORD).
- A write_start pulse while a lane is not IDLE is ignored by that lane.
- Beats with serial_en=1 while the lane is IDLE are dropped.
- Reset at any point: return to IDLE, clear counters, no write issued on the reset cycle or the following one.

## Timing
- Reset values: write_idle=1, sram_we=0, sram_addr=0, sram_wdata=0, ovf_err=0.
- Latency: sram_we rises exactly 1 cycle after the clock edge that accepts the completing beat.
- The lane returns to IDLE on the cycle after its last write. write_idle rises 1 cycle after that, because it is registered.
- write_idle drops within 2 cycles of write_start when img_size>0.
- The lane accepts one beat per cycle at full rate with no back-pressure; the upstream never stalls.

## Configuration
- `J_DESHIFT_OVERFLOW_CHK_EN` defined: ovf_err[i] is set sticky on either of:
  - serial_en[i]=1 while lane i is IDLE, or
  - more than img_size beats arriving in one run.
  - It is cleared only by reset or the next accepted start.
- Undefined: ovf_err is tied to 0 and no check logic is built.

## Structure
- Shared package holds:
  - the clog2 function
  - the lane state enum (IDLE, RUN, WRITE)
  - the lane count 8
  - ELEMS_PER_WORD default
- Sub-module `j_ofm_deshifter`: one lane, instantiated 8 times by a generate loop.
- The top contains only start registration, idle reduction and port slicing.

## Test plan
- Single lane: img_size=8, base=0x10, beats 0x01..0x08 back-to-back. Expect writes 0x04030201 @0x10 and 0x08070605 @0x11, then write_idle=1.
- img_size=5 with gapped serial_en (1 every 3 cycles). Expect the second write to be 0x00000005 @base+1, and exactly 2 writes.
- img_size=0. Expect no sram_we and write_idle to stay 1 (at most 1 cycle low).
- Base at 2^SRAM_ADDR_W-1 with img_size=8. Expect the second write at address 0.
- Reset asserted mid-word after 2 beats. Expect no write, all outputs at reset values, and a clean rerun afterwards.
- Macro on: 3 beats on lane 2 while IDLE. Expect ovf_err[2]=1, other bits 0, cleared by the next start.

Source files
------------

// File: rtl/j_ofm_deshifter_mx_cell_pkg.sv
// rtl/j_ofm_deshifter_mx_cell_pkg.sv - shared types and constants for the OFM deshifter
package j_ofm_deshifter_mx_cell_pkg;

    localparam int NUM_LANES          = 8;
    localparam int ELEMS_PER_WORD_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WRITE
    } lane_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >>> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/j_ofm_deshifter_mx_cell_lane.sv
// rtl/j_ofm_deshifter_mx_cell_lane.sv - one deshifter lane: packs beats into words and writes a bank
// Optional overflow detection under J_DESHIFT_OVERFLOW_CHK_EN.
module j_ofm_deshifter
    import j_ofm_deshifter_mx_cell_pkg::*;
#(
    parameter int SHIFT_WIDTH    = 8,
    parameter int ELEMS_PER_WORD = ELEMS_PER_WORD_DEF,
    parameter int SRAM_ADDR_W    = 18,
    localparam int SRAM_DATA_W   = SHIFT_WIDTH * ELEMS_PER_WORD
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [SRAM_ADDR_W-1:0] base_addr,
    input  logic [SRAM_ADDR_W-1:0] img_size,
    input  logic [SHIFT_WIDTH-1:0] serial_input,
    input  logic                   serial_en,
    output logic                   lane_idle,
    output logic                   sram_we,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_wdata,
    output logic                   ovf_err
);

    localparam int SLOT_W = (ELEMS_PER_WORD > 1) ? clog2(ELEMS_PER_WORD) : 1;

    lane_state_e            state;
    logic [SRAM_ADDR_W-1:0] img_lat;
    logic [SRAM_ADDR_W-1:0] wr_addr;
    logic [SRAM_ADDR_W-1:0] elem_cnt;
    logic [SLOT_W-1:0]      slot_cnt;
    logic [SRAM_DATA_W-1:0] pack;
    logic [SRAM_DATA_W-1:0] packed_c;
    logic                   remaining;
    logic                   accept;
    logic                   complete;

    // sram_wdata is the second buffer: once a word is handed to it, pack restarts
    // empty, so a beat landing in the WRITE cycle goes straight into the next word.
    assign remaining = (elem_cnt != img_lat);
    assign accept    = serial_en && ((state == ST_RUN) || ((state == ST_WRITE) && remaining));
    assign complete  = accept && ((slot_cnt == SLOT_W'(ELEMS_PER_WORD - 1)) ||
                                  (elem_cnt == img_lat - SRAM_ADDR_W'(1)));
    assign lane_idle = (state == ST_IDLE);

    always_comb begin
        packed_c = pack;
        packed_c[slot_cnt*SHIFT_WIDTH +: SHIFT_WIDTH] = serial_input;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            img_lat    <= '0;
            wr_addr    <= '0;
            elem_cnt   <= '0;
            slot_cnt   <= '0;
            pack       <= '0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            sram_we <= 1'b0;
            if (accept) begin
                elem_cnt <= elem_cnt + SRAM_ADDR_W'(1);
                if (complete) begin
                    pack       <= '0;
                    slot_cnt   <= '0;
                    sram_we    <= 1'b1;
                    sram_addr  <= wr_addr;
                    sram_wdata <= packed_c;
                    wr_addr    <= wr_addr + SRAM_ADDR_W'(1);
                end else begin
                    pack     <= packed_c;
                    slot_cnt <= slot_cnt + SLOT_W'(1);
                end
            end
            case (state)
                ST_IDLE: begin
                    if (start && (img_size != '0)) begin
                        img_lat  <= img_size;
                        wr_addr  <= base_addr;
                        elem_cnt <= '0;
                        slot_cnt <= '0;
                        pack     <= '0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (complete) state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (complete)       state <= ST_WRITE;
                    else if (remaining) state <= ST_RUN;
                    else                state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef J_DESHIFT_OVERFLOW_CHK_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            ovf_q <= 1'b0;
        end else if (serial_en && ((state == ST_IDLE) || ((state == ST_WRITE) && !remaining))) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_err = ovf_q;
`else
    assign ovf_err = 1'b0;
`endif

endmodule

// File: rtl/j_ofm_deshifter_mx_cell.sv
// rtl/j_ofm_deshifter_mx_cell.sv - eight-lane OFM deshifter top; optional J_DESHIFT_OVERFLOW_CHK_EN
// Registers the start pulse, fans it to the lanes and reduces their idle flags.
module j_ofm_deshifter_mx_cell
    import j_ofm_deshifter_mx_cell_pkg::*;
#(
    parameter int SRAM_DEPTH     = 256 * 256 * 4,
    parameter int SHIFT_WIDTH    = 8,
    parameter int ELEMS_PER_WORD = ELEMS_PER_WORD_DEF,
    parameter int SRAM_ADDR_W    = clog2(SRAM_DEPTH),
    localparam int SRAM_DATA_W   = SHIFT_WIDTH * ELEMS_PER_WORD
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             write_start,
    output logic                             write_idle,
    input  logic [SRAM_ADDR_W*NUM_LANES-1:0] base_addr,
    input  logic [SRAM_ADDR_W-1:0]           img_size,
    input  logic [SHIFT_WIDTH*NUM_LANES-1:0] serial_input,
    input  logic [NUM_LANES-1:0]             serial_en,
    output logic [NUM_LANES-1:0]             sram_we,
    output logic [SRAM_ADDR_W*NUM_LANES-1:0] sram_addr,
    output logic [SRAM_DATA_W*NUM_LANES-1:0] sram_wdata,
    output logic [NUM_LANES-1:0]             ovf_err
);

    logic                 start_q;
    logic [NUM_LANES-1:0] lane_idle;

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q    <= 1'b0;
            write_idle <= 1'b1;
        end else begin
            start_q    <= write_start;
            write_idle <= &lane_idle;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        j_ofm_deshifter #(
            .SHIFT_WIDTH    (SHIFT_WIDTH),
            .ELEMS_PER_WORD (ELEMS_PER_WORD),
            .SRAM_ADDR_W    (SRAM_ADDR_W)
        ) u_lane (
            .clk          (clk),
            .reset        (reset),
            .start        (start_q),
            .base_addr    (base_addr[i*SRAM_ADDR_W +: SRAM_ADDR_W]),
            .img_size     (img_size),
            .serial_input (serial_input[i*SHIFT_WIDTH +: SHIFT_WIDTH]),
            .serial_en    (serial_en[i]),
            .lane_idle    (lane_idle[i]),
            .sram_we      (sram_we[i]),
            .sram_addr    (sram_addr[i*SRAM_ADDR_W +: SRAM_ADDR_W]),
            .sram_wdata   (sram_wdata[i*SRAM_DATA_W +: SRAM_DATA_W]),
            .ovf_err      (ovf_err[i])
        );
    end

endmodule
